// File: rtl/vnc2_rx_pkg.sv
// Shared definitions for the VNC2 serial receiver: FSM encodings, sample points and the baud divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Purpose : state encodings, oversample sample indices, majority helper.
// Macro   : VNC2_RX_DIV(clk_hz, baud) gives clocks per 16x oversample tick, integer-truncated.
`ifndef VNC2_RX_PKG_SV
`define VNC2_RX_PKG_SV

`define VNC2_RX_DIV(clk_hz, baud) ((clk_hz) / ((baud) * 16))

package vnc2_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Oversample ratio; the sample counter is 4 bits wide, so this is fixed.
  localparam int OVS = 16;

  // Three samples around mid-bit; the bit value is their majority.
  localparam logic [3:0] SMP_A = 4'd7;
  localparam logic [3:0] SMP_B = 4'd8;
  localparam logic [3:0] SMP_C = 4'd9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`endif

// File: rtl/vnc2_uart_rx_if.sv
// Receiver pin/decoder bundle: serial line in, scancode byte and status pulses out.
// Latency: n/a (wires only).
// Backpressure: none; the decoder must take valid_o when it pulses.
// Ports: rx (line), data_o (last good byte), valid_o / frame_err (1-clk pulses), busy_o (frame in progress).
// slave modport is the receiver; master modport is the line driver / byte consumer.
interface vnc2_uart_rx_if;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err;
  logic       busy_o;

  modport master (output rx, input data_o, valid_o, frame_err, busy_o);
  modport slave  (input rx, output data_o, valid_o, frame_err, busy_o);
endinterface

// File: rtl/vnc2_baud_tick.sv
// Free-running divider producing a 1-clk tick every DIV clocks (16x the line rate).
// Latency: first tick DIV clocks after reset release.
// Backpressure: none; never resynchronised to the line.
// Ports: clk, reset_n (async active-low), tick (output pulse).
module vnc2_baud_tick #(
  parameter int DIV = 27
) (
  input  logic reset_n,
  input  logic clk,
  output logic tick
);
  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/vnc2_uart_rx.sv
// 8N1 UART receiver, 16x oversampled, majority vote at samples 7/8/9; feeds the key-matrix decoder.
// Latency: valid_o ~2 sync clks + 9.5 bit-times (+ up to one tick) after the start edge.
// Backpressure: none; data_o holds the last good byte until the next valid_o.
// Ports: clk, reset_n (async active-low), bus (vnc2_uart_rx_if.slave: rx in; data_o, valid_o, frame_err, busy_o out).
// Optional: define VNC2_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module vnc2_uart_rx
  import vnc2_rx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic          clk,
  input  logic          reset_n,
  vnc2_uart_rx_if.slave bus
);
  localparam int DIV = `VNC2_RX_DIV(CLK_HZ, BAUD);

  logic       rx_meta, rx_s, tick, vote;
  rx_state_t  state, state_nx;
  logic [3:0] sc, sc_nx;
  logic [2:0] bit_idx, bit_nx;
  logic [7:0] shreg, shreg_nx, data_q, data_nx;
  logic       smp_a, smp_a_nx, smp_b, smp_b_nx;
  logic       valid_q, valid_nx, ferr_q, ferr_nx;
`ifdef VNC2_RX_PARITY_EN
  logic       par_bad, par_bad_nx;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  vnc2_baud_tick #(.DIV(DIV)) u_tick (
    .reset_n (reset_n),
    .clk     (clk),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      smp_a   <= 1'b1;
      smp_b   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef VNC2_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      sc      <= sc_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
      smp_a   <= smp_a_nx;
      smp_b   <= smp_b_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
`ifdef VNC2_RX_PARITY_EN
      par_bad <= par_bad_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    sc_nx    = sc;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    smp_a_nx = smp_a;
    smp_b_nx = smp_b;
    data_nx  = data_q;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
`ifdef VNC2_RX_PARITY_EN
    par_bad_nx = par_bad;
`endif
    // The third sample is the live synchronised line at sc=SMP_C.
    vote = maj3(smp_a, smp_b, rx_s);

    if (tick) begin
      if (sc == SMP_A) smp_a_nx = rx_s;
      if (sc == SMP_B) smp_b_nx = rx_s;

      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nx = ST_START;
            sc_nx    = '0;
          end
        end
        ST_START: begin
          sc_nx = sc + 1'b1;
          if (sc == SMP_C) begin
            if (vote) begin
              state_nx = ST_IDLE;  // glitch shorter than half a bit
            end else begin
              state_nx = ST_DATA;
              bit_nx   = '0;
            end
          end
        end
        // State changes happen at mid-bit; the next state's decision waits for the next sc=SMP_C,
        // which is the middle of the following bit because sc wraps 15->0 at each bit boundary.
        ST_DATA: begin
          sc_nx = sc + 1'b1;
          if (sc == SMP_C) begin
            shreg_nx = {vote, shreg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef VNC2_RX_PARITY_EN
              state_nx = ST_PARITY;
`else
              state_nx = ST_STOP;
`endif
            end else begin
              bit_nx = bit_idx + 1'b1;
            end
          end
        end
`ifdef VNC2_RX_PARITY_EN
        ST_PARITY: begin
          sc_nx = sc + 1'b1;
          if (sc == SMP_C) begin
            par_bad_nx = vote ^ (^shreg);  // even parity over data + parity bit
            state_nx   = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          sc_nx = sc + 1'b1;
          if (sc == SMP_C) begin
            if (!vote) begin
              ferr_nx  = 1'b1;
              state_nx = ST_BREAK;
              sc_nx    = '0;
`ifdef VNC2_RX_PARITY_EN
            end else if (par_bad) begin
              ferr_nx  = 1'b1;
              state_nx = ST_IDLE;
`endif
            end else begin
              data_nx  = shreg;
              valid_nx = 1'b1;
              state_nx = ST_IDLE;  // leave at mid-stop so a back-to-back start is caught
            end
          end
        end
        // sc counts consecutive high ticks; any low tick restarts the count.
        ST_BREAK: begin
          if (!rx_s) begin
            sc_nx = '0;
          end else if (sc == 4'(OVS - 1)) begin
            sc_nx    = '0;
            state_nx = ST_IDLE;
          end else begin
            sc_nx = sc + 1'b1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          sc_nx    = '0;
        end
      endcase
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy_o    = (state != ST_IDLE);
endmodule

// File: tb/tb_vnc2_uart_rx.sv
`timescale 1ns/1ps
module tb_vnc2_uart_rx;
  // Bench clock chosen so one oversample tick is 4 clocks and a bit is 64 clocks.
  localparam int  CLK_HZ = 7_372_800;
  localparam int  BAUD   = 115200;
  localparam int  DIV    = CLK_HZ / (BAUD * 16);
  localparam real BT     = 16.0 * DIV;
  localparam int  HOLD_2MS = 14746;  // 2 ms at CLK_HZ

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  vnc2_uart_rx_if u_if();

  vnc2_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] dat;
    int         t0;
  } ev_t;

  ev_t        evq[$];
  ev_t        cur_ev;
  logic [7:0] exp_data = 8'h00;
  int n_chk = 0, n_pass = 0, n_valid = 0, n_ferr = 0;
  bit busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  // Model: every complete frame sent predicts exactly one outcome (good byte or frame error)
  // that must appear about 9.5 bit-times after its start edge; data_o only ever changes to a good byte.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (u_if.busy_o) busy_seen = 1'b1;
      chk("valid_ferr_exclusive", {31'd0, u_if.valid_o & u_if.frame_err}, 32'd0);
      if (u_if.valid_o || u_if.frame_err) begin
        chk("pending_event", {31'd0, evq.size() > 0}, 32'd1);
        if (evq.size() > 0) begin
          cur_ev = evq.pop_front();
          chk("event_kind_ferr", {31'd0, u_if.frame_err}, {31'd0, cur_ev.is_err});
          chk_rng("event_latency", cyc - cur_ev.t0, int'(9.0 * BT), int'(10.0 * BT));
          if (!cur_ev.is_err) exp_data = cur_ev.dat;
        end
        if (u_if.valid_o) n_valid++;
        if (u_if.frame_err) n_ferr++;
      end
      chk("data_hold", {24'd0, u_if.data_o}, {24'd0, exp_data});
    end
  end

  task automatic idle(input int n);
    u_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame with the given bit period scale; cut>0 stops after that many clocks (no outcome expected).
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit flip_par,
                            input real scale, input int cut);
    logic bits[11];
    int   nb, total, idx;
    real  bt;
    ev_t  e;
    bt = BT * scale;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    nb = 9;
    e.is_err = !stop_bit;
`ifdef VNC2_RX_PARITY_EN
    bits[9] = (^b) ^ flip_par;
    nb = 10;
    e.is_err = e.is_err | flip_par;
`else
    if (flip_par) $display("note: parity flip ignored in 8N1 build");
`endif
    bits[nb] = stop_bit;
    nb++;
    total = int'(nb * bt);
    e.dat = b;
    e.t0  = cyc;
    if (cut > 0) total = cut;
    else evq.push_back(e);
    idx = 0;
    for (int c = 0; c < total; c++) begin
      while (idx < nb - 1 && real'(c) >= (idx + 1) * bt) idx++;
      u_if.rx = bits[idx];
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (u_if.busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, u_if.busy_o}, 32'd0);
  endtask

  initial begin
    int v0, f0;
    u_if.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data",  {24'd0, u_if.data_o}, 32'h00);
    chk("reset_valid", {31'd0, u_if.valid_o}, 32'd0);
    chk("reset_ferr",  {31'd0, u_if.frame_err}, 32'd0);
    chk("reset_busy",  {31'd0, u_if.busy_o}, 32'd0);
    reset_n = 1'b1;
    idle(int'(2 * BT));

    // 1: single scancode, nominal and +/-2% skew
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h04, 1'b1, 1'b0, 1.0, 0);
    idle(int'(BT));
    wait_idle("t1_idle", 200);
    chk("t1_data", {24'd0, u_if.data_o}, 32'h04);
    chk("t1_valid_cnt", n_valid - v0, 32'd1);
    chk("t1_ferr_cnt", n_ferr - f0, 32'd0);
    v0 = n_valid;
    send_frame(8'h04, 1'b1, 1'b0, 1.02, 0);
    idle(int'(BT));
    send_frame(8'h04, 1'b1, 1'b0, 0.98, 0);
    idle(int'(BT));
    chk("t1_skew_valid_cnt", n_valid - v0, 32'd2);
    chk("t1_skew_ferr_cnt", n_ferr - f0, 32'd0);

    // 2: back-to-back, zero idle gap
    v0 = n_valid;
    send_frame(8'h3a, 1'b1, 1'b0, 1.0, 0);
    send_frame(8'h45, 1'b1, 1'b0, 1.0, 0);
    idle(int'(BT));
    wait_idle("t2_idle", 200);
    chk("t2_data", {24'd0, u_if.data_o}, 32'h45);
    chk("t2_valid_cnt", n_valid - v0, 32'd2);

    // 3: 3/16-bit low glitch
    v0 = n_valid; f0 = n_ferr;
    busy_seen = 1'b0;
    u_if.rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    idle(20 * DIV);
    wait_idle("t3_busy_drop", 40 * DIV);
    chk("t3_busy_seen", {31'd0, busy_seen}, 32'd1);
    chk("t3_valid_cnt", n_valid - v0, 32'd0);
    chk("t3_ferr_cnt", n_ferr - f0, 32'd0);
    chk("t3_data", {24'd0, u_if.data_o}, 32'h45);

    // 4: bad stop bit, line held low, then BREAK recovery
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h28, 1'b0, 1'b0, 1.0, 0);
    u_if.rx = 1'b0;
    repeat (HOLD_2MS) @(negedge clk);
    chk("t4_break_busy", {31'd0, u_if.busy_o}, 32'd1);
    idle(10 * DIV);
    chk("t4_break_not_yet", {31'd0, u_if.busy_o}, 32'd1);
    idle(6 * DIV);
    wait_idle("t4_break_exit", 8 * DIV);
    chk("t4_ferr_cnt", n_ferr - f0, 32'd1);
    chk("t4_valid_cnt", n_valid - v0, 32'd0);
    chk("t4_data_kept", {24'd0, u_if.data_o}, 32'h45);
    idle(int'(BT));
    send_frame(8'h2c, 1'b1, 1'b0, 1.0, 0);
    idle(int'(BT));
    chk("t4_next_data", {24'd0, u_if.data_o}, 32'h2c);
    chk("t4_next_valid_cnt", n_valid - v0, 32'd1);

    // 5: reset during bit 4 of 8'hff
    send_frame(8'hff, 1'b1, 1'b0, 1.0, int'(5.5 * BT));
    chk("t5_busy_before", {31'd0, u_if.busy_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    exp_data = 8'h00;
    evq.delete();
    #1;
    chk("t5_rst_data",  {24'd0, u_if.data_o}, 32'h00);
    chk("t5_rst_valid", {31'd0, u_if.valid_o}, 32'd0);
    chk("t5_rst_ferr",  {31'd0, u_if.frame_err}, 32'd0);
    chk("t5_rst_busy",  {31'd0, u_if.busy_o}, 32'd0);
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    idle(int'(2 * BT));
    send_frame(8'h1e, 1'b1, 1'b0, 1.0, 0);
    idle(int'(BT));
    chk("t5_data", {24'd0, u_if.data_o}, 32'h1e);
    chk("t5_valid_cnt", n_valid - v0, 32'd1);
    chk("t5_ferr_cnt", n_ferr - f0, 32'd0);

`ifdef VNC2_RX_PARITY_EN
    // 6: parity
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h07, 1'b1, 1'b1, 1.0, 0);
    idle(int'(BT));
    wait_idle("t6_bad_par_idle", 200);
    chk("t6_bad_ferr_cnt", n_ferr - f0, 32'd1);
    chk("t6_bad_valid_cnt", n_valid - v0, 32'd0);
    chk("t6_bad_data_kept", {24'd0, u_if.data_o}, 32'h1e);
    send_frame(8'h07, 1'b1, 1'b0, 1.0, 0);
    idle(int'(BT));
    chk("t6_good_data", {24'd0, u_if.data_o}, 32'h07);
    chk("t6_good_valid_cnt", n_valid - v0, 32'd1);
`endif

    idle(int'(2 * BT));
    chk("all_events_seen", evq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
